rej_sampler: RTL and testbench

Uniform rejection sampler feeding the polynomial RAM consumed by the NTT/MULT datapath. It takes a SHAKE128 byte stream and parses every 3 bytes into two 12-bit candidates. Candidates ≥ Q are rejected; accepted coefficients are packed 8 per 96-bit word and written as 32 consecutive words, one 256-coefficient NTT-domain polynomial of matrix A. The written words sit at the offset later supplied to the processor as `r_start_offset_B` in MULT mode.

---
 rtl/rej_sampler_pkg.sv | 19 +
 rtl/rej_parse.sv | 52 +++++
 rtl/rej_sampler.sv | 92 +++++++++
 tb/tb_rej_sampler.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rej_sampler_pkg.sv
// Shared Kyber constants and the sampler FSM state type.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rej_sampler_pkg;

   localparam int KYBER_Q        = 3329;
   localparam int KYBER_N        = 256;
   localparam int COEF_W         = 12;
   localparam int WORD_W         = 96;
   localparam int WORDS_PER_POLY = 32;
   localparam int ADDR_W         = 9;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/rej_parse.sv
// Byte-phase tracker: turns a byte stream into 12-bit candidates and flags those below Q.
// Latency: combinational candidate on the transfer cycle of bytes 1 and 2 of each triplet.
// Backpressure: state only advances when xfer is high; stalls hold all state.
// Ports: clk, rst, clear (restart at phase 0), xfer (byte handshake), in_byte,
//        cand_valid (accepted candidate this cycle), cand (candidate value).
module rej_parse
   import rej_sampler_pkg::*;
#(
   parameter int Q = KYBER_Q
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clear,
   input  logic                xfer,
   input  logic [7:0]          in_byte,
   output logic                cand_valid,
   output logic [COEF_W-1:0]   cand
);

   logic [1:0] phase;
   logic [7:0] b0;
   logic [3:0] nib;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase <= 2'd0;
         b0    <= 8'd0;
         nib   <= 4'd0;
      end else if (clear) begin
         phase <= 2'd0;
      end else if (xfer) begin
         case (phase)
            2'd0: begin
               b0    <= in_byte;
               phase <= 2'd1;
            end
            2'd1: begin
               nib   <= in_byte[7:4];
               phase <= 2'd2;
            end
            default: phase <= 2'd0;
         endcase
      end
   end

   always_comb begin
      cand       = (phase == 2'd1) ? {in_byte[3:0], b0} : {in_byte, nib};
      // Phase 0 only stores a byte; it never produces a candidate.
      cand_valid = xfer && (phase != 2'd0) && (cand < COEF_W'(Q));
   end

endmodule

// File: rtl/rej_sampler.sv
// Uniform rejection sampler: packs accepted coefficients 8 per word, writes 32 words per polynomial.
// Latency: w_data_en one cycle after the transfer that fills slot 7; finish with the 32nd write.
// Backpressure: in_ready is a pure state decode (high in RUN); in_valid low stalls everything.
// Ports: clk, rst, start, w_addr_offset, in_byte/in_valid/in_ready (byte stream),
//        w_data/w_data_addr/w_data_en (RAM write port), finish.
module rej_sampler
   import rej_sampler_pkg::*;
#(
   parameter int Q       = KYBER_Q,
   parameter int N_WORDS = WORDS_PER_POLY
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [8:0]        w_addr_offset,
   input  logic [7:0]        in_byte,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [95:0]       w_data,
   output logic [8:0]        w_data_addr,
   output logic              w_data_en,
   output logic              finish
);

   state_t              state, state_nxt;
   logic [2:0]          slot;
   logic [4:0]          word_cnt;
   logic [ADDR_W-1:0]   offset;
   logic [WORD_W-1:0]   pack;

   logic                clear, xfer, acc, word_full, last;
   logic [COEF_W-1:0]   cand;

   assign in_ready  = (state == ST_RUN);
   assign finish    = (state == ST_DONE);
   assign clear     = start && (state == ST_IDLE);
   assign xfer      = in_valid && in_ready;
   assign word_full = acc && (slot == 3'd7);
   assign last      = word_full && (word_cnt == 5'(N_WORDS - 1));

   rej_parse #(.Q(Q)) u_parse (
      .clk        (clk),
      .rst        (rst),
      .clear      (clear),
      .xfer       (xfer),
      .in_byte    (in_byte),
      .cand_valid (acc),
      .cand       (cand)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (start) state_nxt = ST_RUN;
         ST_RUN:  if (last)  state_nxt = ST_DONE;
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         slot        <= 3'd0;
         word_cnt    <= 5'd0;
         offset      <= '0;
         pack        <= '0;
         w_data      <= '0;
         w_data_addr <= '0;
         w_data_en   <= 1'b0;
      end else begin
         state     <= state_nxt;
         w_data_en <= word_full;
         if (clear) begin
            slot     <= 3'd0;
            word_cnt <= 5'd0;
            offset   <= w_addr_offset;
            pack     <= '0;
         end else if (acc) begin
            pack[slot*COEF_W +: COEF_W] <= cand;
            slot <= slot + 3'd1;
            if (word_full) begin
               // The eighth coefficient bypasses the pack register straight into the word.
               w_data      <= {cand, pack[7*COEF_W-1:0]};
               w_data_addr <= offset + ADDR_W'(word_cnt);
               word_cnt    <= word_cnt + 5'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_rej_sampler.sv
module tb_rej_sampler;

   typedef struct packed {
      logic [8:0]  addr;
      logic [95:0] data;
   } wr_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [8:0]  w_addr_offset;
   logic [7:0]  in_byte;
   logic        in_valid;
   logic        in_ready;
   logic [95:0] w_data;
   logic [8:0]  w_data_addr;
   logic        w_data_en;
   logic        finish;

   int          errors = 0;
   int          checks = 0;
   int          n_writes = 0;
   bit          finish_seen = 0;
   logic [7:0]  stream[$];
   wr_t         exp_q[$];

   always #5 clk = ~clk;

   rej_sampler dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .w_addr_offset (w_addr_offset),
      .in_byte       (in_byte),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .w_data        (w_data),
      .w_data_addr   (w_data_addr),
      .w_data_en     (w_data_en),
      .finish        (finish)
   );

   task automatic check(input string name, input logic [95:0] got, input logic [95:0] expv);
      checks++;
      if (got !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, expv);
      end
   endtask

   // Reference model: walk the byte stream triplet by triplet, build the list of accepted
   // coefficients, and emit one expected write per 8 of them. Returns bytes consumed up to
   // the 256th acceptance, or -1 if the limit is reached first.
   function automatic int model(input logic [8:0] off, input int limit);
      int          cnt = 0;
      int          w = 0;
      int          d;
      logic [95:0] word = '0;
      wr_t         e;
      for (int i = 0; i < limit && i < stream.size(); i++) begin
         if (i % 3 == 0) continue;
         if (i % 3 == 1) d = int'(stream[i-1]) + 256 * (int'(stream[i]) % 16);
         else            d = int'(stream[i-1]) / 16 + 16 * int'(stream[i]);
         if (d < 3329) begin
            word[(cnt % 8) * 12 +: 12] = d[11:0];
            cnt++;
            if (cnt % 8 == 0) begin
               e.addr = 9'((int'(off) + w) % 512);
               e.data = word;
               exp_q.push_back(e);
               w++;
               word = '0;
            end
            if (cnt == 256) return i + 1;
         end
      end
      return -1;
   endfunction

   // Monitor: every write is popped against the scoreboard.
   always @(negedge clk) begin
      wr_t e;
      if (!rst) begin
         if (w_data_en) begin
            n_writes++;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL extra_write: got write to %0h, expected none", w_data_addr);
            end else begin
               e = exp_q.pop_front();
               check("w_data_addr", 96'(w_data_addr), 96'(e.addr));
               check("w_data", w_data, e.data);
            end
         end
         if (finish) begin
            finish_seen = 1;
            check("finish_on_last_write", 96'({w_data_en, exp_q.size() == 0}), 96'(2'b11));
         end
      end
   end

   // Runs one polynomial over the current stream. vprob = percent of cycles with in_valid.
   task automatic run_poly(input logic [8:0] off, input int vprob, input int probe, input bit noise);
      int  idx = 0;
      int  cyc = 0;
      int  exp_cons;
      bit  probed = 0;
      bit  v;
      exp_cons = model(off, stream.size());
      n_writes = 0;
      finish_seen = 0;
      @(negedge clk);
      start = 1'b1;
      w_addr_offset = off;
      @(negedge clk);
      start = 1'b0;
      while (!finish_seen && cyc < 5000) begin
         if (probe > 0 && idx == probe && !probed) begin
            probed = 1;
            check("probe_no_writes", 96'(n_writes), 96'(0));
            check("probe_in_ready", 96'(in_ready), 96'(1));
         end
         v = ($urandom_range(99) < vprob) && (idx < stream.size());
         in_valid = v;
         in_byte  = v ? stream[idx] : 8'($urandom);
         // A start during RUN/DONE must be ignored.
         start = noise && ($urandom_range(15) == 0);
         if (start) w_addr_offset = 9'($urandom);
         if (v && in_ready) idx++;
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      in_valid = 1'b0;
      if (!finish_seen) begin
         checks++;
         errors++;
         $display("FAIL finish_timeout: got no finish, expected finish within 5000 cycles");
      end
      check("bytes_consumed", 96'(idx), 96'(exp_cons));
      check("write_count", 96'(n_writes), 96'(32));
      check("scoreboard_empty", 96'(exp_q.size()), 96'(0));
      @(negedge clk);
      check("in_ready_after", 96'(in_ready), 96'(0));
      check("finish_after", 96'(finish), 96'(0));
      exp_q.delete();
   endtask

   task automatic fill_random(input int n);
      stream.delete();
      for (int i = 0; i < n; i++) stream.push_back(8'($urandom));
   endtask

   initial begin
      int idx;
      int cyc;
      int exp_partial;
      rst = 1'b1;
      start = 1'b0;
      in_valid = 1'b0;
      in_byte = 8'd0;
      w_addr_offset = 9'd0;
      repeat (2) @(negedge clk);
      check("rst_in_ready", 96'(in_ready), 96'(0));
      check("rst_w_data_en", 96'(w_data_en), 96'(0));
      check("rst_finish", 96'(finish), 96'(0));
      check("rst_w_data", w_data, 96'(0));
      check("rst_w_data_addr", 96'(w_data_addr), 96'(0));
      rst = 1'b0;

      // All-zero stream, continuous valid.
      stream.delete();
      for (int i = 0; i < 420; i++) stream.push_back(8'h00);
      run_poly(9'h040, 100, 0, 0);

      // Boundary triplet: 3329 rejected, 3328 accepted.
      stream.delete();
      for (int i = 0; i < 270; i++) begin
         stream.push_back(8'h01);
         stream.push_back(8'h0D);
         stream.push_back(8'hD0);
      end
      run_poly(9'h000, 100, 0, 0);

      // 30 bytes of 0xFF (all rejected) then zeros.
      stream.delete();
      for (int i = 0; i < 30; i++) stream.push_back(8'hFF);
      for (int i = 0; i < 420; i++) stream.push_back(8'h00);
      run_poly(9'h123, 100, 30, 0);

      // Random bytes with gappy valid and stray start pulses.
      fill_random(1000);
      run_poly(9'h0A5, 60, 0, 1);

      // Address wrap past 0x1FF.
      fill_random(1000);
      run_poly(9'h1F0, 85, 0, 0);

      // Reset after 100 bytes: complete words are written, the partial one is not.
      fill_random(200);
      exp_partial = model(9'h100, 100);
      exp_partial = exp_q.size();
      n_writes = 0;
      @(negedge clk);
      start = 1'b1;
      w_addr_offset = 9'h100;
      @(negedge clk);
      start = 1'b0;
      idx = 0;
      cyc = 0;
      while (idx < 100 && cyc < 1000) begin
         in_valid = 1'b1;
         in_byte  = stream[idx];
         if (in_ready) idx++;
         @(negedge clk);
         cyc++;
      end
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("abort_in_ready", 96'(in_ready), 96'(0));
      check("abort_w_data_en", 96'(w_data_en), 96'(0));
      check("abort_w_data", w_data, 96'(0));
      check("abort_w_data_addr", 96'(w_data_addr), 96'(0));
      check("abort_writes", 96'(n_writes), 96'(exp_partial));
      check("abort_scoreboard", 96'(exp_q.size()), 96'(0));
      exp_q.delete();
      rst = 1'b0;
      @(negedge clk);
      check("idle_in_ready", 96'(in_ready), 96'(0));

      // Restart after reset at a fresh offset.
      fill_random(1000);
      run_poly(9'h080, 70, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
